tap_rec: RTL



---
 rtl/tap_rec.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/tap_rec.sv
// SAVE decoder: measures MIC half-pulse widths in T-states, decodes ROM pilot/sync/data
// encoding and writes each block into the tap store as a TAP record (length, then data).
module tap_rec #(
  parameter int          PILOT_MIN = 256,
  parameter int          PILOT_LO  = 1900,
  parameter int          PILOT_HI  = 2500,
  parameter int          SYNC_MAX  = 800,
  parameter int          BIT_SPLIT = 1283,
  parameter int          BIT_MAX   = 2200,
  parameter int          SILENCE   = 7000,
  parameter logic [16:0] LAST_ADDR = 17'h1FFFF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        tstate,
  input  logic        mic_in,
  input  logic        arm,
  output logic [16:0] tap_address,
  output logic [7:0]  tap_data,
  output logic        tap_we,
  output logic        busy,
  output logic [7:0]  blocks,
  output logic        err,
  output logic        full
);

  typedef enum logic [2:0] {
    S_IDLE, S_PILOT, S_SYNC, S_DATA, S_END, S_LEN_LO, S_LEN_HI, S_FULL
  } state_t;

  localparam logic [15:0] W_PLO   = 16'(PILOT_LO);
  localparam logic [15:0] W_PHI   = 16'(PILOT_HI);
  localparam logic [15:0] W_SYNC  = 16'(SYNC_MAX);
  localparam logic [15:0] W_SPLIT = 16'(BIT_SPLIT);
  localparam logic [15:0] W_BMAX  = 16'(BIT_MAX);
  localparam logic [15:0] W_SIL   = 16'(SILENCE);
  localparam logic [9:0]  P_MIN   = 10'(PILOT_MIN);

  state_t      state, state_n;
  logic [15:0] cnt, len;
  logic [9:0]  pcount;
  logic [16:0] blk_start;
  logic [7:0]  shreg;
  logic [2:0]  nbit;
  logic        mic_q, arm_q, half, first_cls;

  logic        mic_edge, arm_rise, silence, is_pilot, is_sync, cls, too_long, at_top;
  logic [17:0] top_sum;
  logic [7:0]  new_byte;
  logic        wr_req, set_err, set_full;
  logic [16:0] wr_addr;
  logic [7:0]  wr_data;

  assign mic_edge = mic_in ^ mic_q;
  assign arm_rise = arm & ~arm_q;
  assign silence  = !mic_edge && (cnt == W_SIL);
  assign is_pilot = (cnt >= W_PLO) && (cnt <= W_PHI);
  assign is_sync  = cnt <= W_SYNC;
  assign cls      = cnt >= W_SPLIT;
  assign too_long = cnt > W_BMAX;
  assign new_byte = {shreg[6:0], cls};
  // Wide sum so an address past the top of the store can never wrap back to look legal
  assign top_sum  = {1'b0, blk_start} + 18'd2 + {2'b00, len};
  assign at_top   = top_sum >= {1'b0, LAST_ADDR};
  assign busy     = (state != S_IDLE) && (state != S_FULL);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n  = state;
    wr_req   = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    set_err  = 1'b0;
    set_full = 1'b0;
    if (!arm) begin
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (mic_edge) state_n = S_PILOT;
        S_PILOT: begin
          if (mic_edge) begin
            if (!is_pilot && is_sync && pcount >= P_MIN) state_n = S_SYNC;
          end else if (silence) state_n = S_IDLE;
        end
        S_SYNC: begin
          if (mic_edge) begin
            if (is_sync) state_n = S_DATA;
            else begin
              state_n = S_IDLE;
              set_err = 1'b1;
            end
          end else if (silence) state_n = S_IDLE;
        end
        S_DATA: begin
          if (mic_edge) begin
            if (too_long || (half && cls != first_cls)) begin
              state_n = S_END;
              set_err = 1'b1;
            end else if (half && nbit == 3'd7) begin
              wr_req  = 1'b1;
              wr_addr = top_sum[16:0];
              wr_data = new_byte;
              if (at_top) begin
                set_full = 1'b1;
                state_n  = S_END;
              end
            end
          end else if (silence) state_n = S_END;
        end
        S_END: begin
          if (len == 16'd0) state_n = S_IDLE;
          else begin
            state_n = S_LEN_LO;
            wr_req  = 1'b1;
            wr_addr = blk_start;
            wr_data = len[7:0];
          end
        end
        S_LEN_LO: begin
          state_n = S_LEN_HI;
          wr_req  = 1'b1;
          wr_addr = blk_start + 17'd1;
          wr_data = len[15:8];
        end
        S_LEN_HI: state_n = full ? S_FULL : S_IDLE;
        S_FULL:   if (arm_rise) state_n = S_IDLE;
        default:  state_n = S_IDLE;
      endcase
    end
  end

  // Pulse timer, decode datapath and registered store port
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      mic_q       <= 1'b0;
      arm_q       <= 1'b0;
      pcount      <= '0;
      len         <= '0;
      nbit        <= '0;
      half        <= 1'b0;
      first_cls   <= 1'b0;
      shreg       <= '0;
      blk_start   <= '0;
      blocks      <= '0;
      err         <= 1'b0;
      full        <= 1'b0;
      tap_we      <= 1'b0;
      tap_address <= '0;
      tap_data    <= '0;
    end else begin
      mic_q  <= mic_in;
      arm_q  <= arm;
      tap_we <= wr_req;
      if (wr_req) begin
        tap_address <= wr_addr;
        tap_data    <= wr_data;
      end
      if (mic_edge)                       cnt <= '0;
      else if (tstate && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
      if (set_err)  err  <= 1'b1;
      if (set_full) full <= 1'b1;
      if (arm) begin
        case (state)
          S_IDLE: pcount <= '0;
          S_PILOT: if (mic_edge) begin
            if (is_pilot) begin
              if (pcount != 10'h3FF) pcount <= pcount + 10'd1;
            end else pcount <= '0;
          end
          S_SYNC: if (mic_edge && is_sync) begin
            len  <= '0;
            nbit <= '0;
            half <= 1'b0;
          end
          S_DATA: if (mic_edge && !too_long) begin
            if (!half) begin
              first_cls <= cls;
              half      <= 1'b1;
            end else begin
              half <= 1'b0;
              if (cls == first_cls) begin
                shreg <= new_byte;
                nbit  <= nbit + 3'd1;
                if (nbit == 3'd7) len <= len + 16'd1;
              end
            end
          end
          S_LEN_HI: begin
            blk_start <= blk_start + {1'b0, len} + 17'd2;
            blocks    <= blocks + 8'd1;
          end
          default: ;
        endcase
      end
      if (arm_rise) begin
        blk_start <= '0;
        blocks    <= '0;
        err       <= 1'b0;
        full      <= 1'b0;
      end
    end
  end

endmodule
